// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, with a fixed access latency.
// Define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests; by default data has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            stateReg, stateNext;
  logic [3:0]        cntReg;
  logic              grantIdReg;
  logic              isStoreReg;
  logic              ifAckReg, dAckReg, memWeReg;
  logic [ADDR_W-1:0] memAddrReg;
  logic [DATA_W-1:0] memWdataReg, ifRdataReg, dRdataReg;
  logic              anyReq;
  logic              winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastWinnerReg;
`endif

  // winner: 0 = fetch, 1 = data
  always_comb begin
    anyReq = if_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && d_req) winner = ~lastWinnerReg;
    else                 winner = d_req;
`else
    winner = d_req;
`endif
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (cntReg == 4'd0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      cntReg      <= 4'd0;
      grantIdReg  <= 1'b0;
      isStoreReg  <= 1'b0;
      ifAckReg    <= 1'b0;
      dAckReg     <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      ifRdataReg  <= '0;
      dRdataReg   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastWinnerReg <= 1'b0;
`endif
    end else begin
      stateReg <= stateNext;
      // acks and the write strobe are single-cycle pulses
      ifAckReg <= 1'b0;
      dAckReg  <= 1'b0;
      memWeReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (anyReq) begin
            grantIdReg <= winner;
            cntReg     <= CNT_INIT;
            isStoreReg <= winner & d_we;
            memWeReg   <= winner & d_we;
            if (winner) begin
              memAddrReg  <= d_addr;
              memWdataReg <= d_wdata;
            end else begin
              memAddrReg  <= if_addr;
            end
`ifdef ARB_ROUND_ROBIN_EN
            lastWinnerReg <= winner;
`endif
          end
        end
        ACCESS: begin
          cntReg <= cntReg - 4'd1;
          if (cntReg == 4'd0) begin
            if (!grantIdReg) begin
              ifRdataReg <= mem_rdata;
              ifAckReg   <= 1'b1;
            end else begin
              if (!isStoreReg) dRdataReg <= mem_rdata;
              dAckReg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (stateReg != IDLE);
  assign grant_id  = grantIdReg;
  assign if_ack    = ifAckReg;
  assign d_ack     = dAckReg;
  assign mem_we    = memWeReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign if_rdata  = ifRdataReg;
  assign d_rdata   = dRdataReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of lone transactions plus tie, held-request and reset sequences.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int LAT = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, if_req, if_ack, d_req, d_we, d_ack, mem_we, busy, grant_id;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  // memory model: returns the vector's data only when the expected address is presented
  logic [AW-1:0] curAddr;
  logic [DW-1:0] curRdata;
  assign mem_rdata = (mem_addr == curAddr) ? curRdata : 64'hBAD0_BAD0_BAD0_BAD0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic          isData;
    logic          we;
    logic [31:0]   addr;
    logic [63:0]   wdata;
    logic [63:0]   memData;
    logic [63:0]   expIf;
    logic [63:0]   expD;
    logic [63:0]   expWdata;
  } vec_t;

  vec_t vecs[5];
  logic [63:0] prevIf, prevD;

  initial begin
    // isData, we, addr, wdata, memData, expIf, expD, expWdata
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 64'h0, 64'h0000_0000_0000_DEAD,
                64'h0000_0000_0000_DEAD, 64'h0, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 64'h0000_0000_0000_1234, 64'h1111_2222_3333_4444,
                64'h0000_0000_0000_DEAD, 64'h0, 64'h0000_0000_0000_1234};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0048, 64'h0000_0000_0000_5555, 64'hCAFE_F00D_1234_5678,
                64'h0000_0000_0000_DEAD, 64'hCAFE_F00D_1234_5678, 64'h0000_0000_0000_5555};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 64'h0, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 64'hCAFE_F00D_1234_5678, 64'h0000_0000_0000_5555};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h9999_9999_9999_9999,
                64'h0123_4567_89AB_CDEF, 64'hCAFE_F00D_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF};

    curAddr = '0; curRdata = '0;
    doReset();
    check("rst_busy", busy, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_grant_id", grant_id, 0);

    // table of lone transactions, each starting in IDLE at cycle 0
    prevIf = '0; prevD = '0;
    for (int i = 0; i < 5; i++) begin
      curAddr = vecs[i].addr; curRdata = vecs[i].memData;
      if (vecs[i].isData) begin
        d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      for (int c = 1; c <= LAT + 2; c++) begin
        step();
        if (c == 1) begin
          // post-grant changes must be ignored
          if_addr = 32'hBEEF_0000; d_addr = 32'hBEEF_0004; d_wdata = 64'hBEEF; d_we = ~d_we;
        end
        if (c <= LAT) begin
          check($sformatf("v%0d_c%0d_mem_addr", i, c), mem_addr, vecs[i].addr);
          check($sformatf("v%0d_c%0d_mem_wdata", i, c), mem_wdata, vecs[i].expWdata);
          check($sformatf("v%0d_c%0d_mem_we", i, c), mem_we, vecs[i].isData && vecs[i].we && c == 1);
          check($sformatf("v%0d_c%0d_busy", i, c), busy, 1);
          check($sformatf("v%0d_c%0d_grant", i, c), grant_id, vecs[i].isData);
          check($sformatf("v%0d_c%0d_acks", i, c), {if_ack, d_ack}, 0);
          check($sformatf("v%0d_c%0d_if_rdata_held", i, c), if_rdata, prevIf);
          check($sformatf("v%0d_c%0d_d_rdata_held", i, c), d_rdata, prevD);
        end else if (c == LAT + 1) begin
          check($sformatf("v%0d_if_ack", i), if_ack, !vecs[i].isData);
          check($sformatf("v%0d_d_ack", i), d_ack, vecs[i].isData);
          check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].expIf);
          check($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].expD);
          check($sformatf("v%0d_resp_busy", i), busy, 1);
          check($sformatf("v%0d_resp_mem_we", i), mem_we, 0);
          if_req = 1'b0; d_req = 1'b0;
        end else begin
          check($sformatf("v%0d_idle_busy", i), busy, 0);
          check($sformatf("v%0d_idle_acks", i), {if_ack, d_ack}, 0);
        end
      end
      $display("txn %0d: %s addr=%h if_rdata=%h d_rdata=%h", i,
               vecs[i].isData ? (vecs[i].we ? "store" : "load ") : "fetch",
               vecs[i].addr, if_rdata, d_rdata);
      prevIf = vecs[i].expIf; prevD = vecs[i].expD;
    end

    // both requesters held from reset
    doReset();
    curAddr = 32'h0000_0100; curRdata = 64'h77;
    if_req = 1'b1; if_addr = 32'h0000_0100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
    for (int c = 1; c <= 11; c++) begin
      step();
      check($sformatf("tie_c%0d_d_ack", c), d_ack, (c == 3) || (c == 11) || (!RR && c == 7));
      check($sformatf("tie_c%0d_if_ack", c), if_ack, RR && c == 7);
      if (c == 1 || c == 5 || c == 9)
        check($sformatf("tie_c%0d_grant", c), grant_id, !(RR && c == 5));
    end
    $display("txn tie: round_robin=%0d", RR);

    // fetch request held through its ack cycle
    doReset();
    curAddr = 32'h0000_0020; curRdata = 64'h42;
    if_req = 1'b1; if_addr = 32'h0000_0020;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 5) if_req = 1'b0;
      check($sformatf("hold_c%0d_busy", c), busy, c != 4);
      check($sformatf("hold_c%0d_if_ack", c), if_ack, c == 3 || c == 7);
    end
    $display("txn hold: regrant after RESP");

    // reset in cycle 2 of a store
    doReset();
    curAddr = 32'h0000_0080; curRdata = 64'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = 64'hABCD;
    step();
    check("rst_mid_c1_mem_we", mem_we, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check("rst_mid_d_ack", d_ack, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem_we", mem_we, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_mem_wdata", mem_wdata, 0);
    check("rst_mid_grant", grant_id, 0);
    step();
    check("rst_mid_c4_d_ack", d_ack, 0);
    curAddr = 32'h0000_0030; curRdata = 64'h5A5A;
    if_req = 1'b1; if_addr = 32'h0000_0030;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      check($sformatf("rst_fetch_c%0d_if_ack", c), if_ack, c == LAT + 1);
      if (c == LAT + 1) begin
        check("rst_fetch_if_rdata", if_rdata, 64'h5A5A);
        if_req = 1'b0;
      end
    end
    $display("txn reset-abort: fresh fetch granted");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates and sequences one shared memory port between the instruction-fetch requester and the data (load/store) requester of the multicycle core. The control unit's fetch and memory-access states issue requests here. The block grants one requester at a time, drives the memory port for a fixed access latency, and returns read data with a one-cycle acknowledge. It sits between the control unit/datapath and the unified memory, replacing separate instruction and data memories.

## Interface
Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 64, data width of all data ports.
- MEM_LATENCY, 2, cycles mem_addr is held before mem_rdata is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge; the only clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; sampled at grant.
- if_rdata  out  DATA_W  fetch read data; updated only in the if_ack cycle, held otherwise.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; sampled at grant.
- d_addr  in  ADDR_W  data address; sampled at grant.
- d_wdata  in  DATA_W  store data; sampled at grant.
- d_rdata  out  DATA_W  load data; updated only on a load d_ack, held otherwise.
- d_ack  out  1  one-cycle data completion pulse, for both loads and stores.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_we  out  1  memory write strobe, registered.
- mem_rdata  in  DATA_W  memory read data; must be valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and RESP.
- grant_id  out  1  owner of the current or most recent transaction: 0 = fetch, 1 = data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, any request pending: pick a winner, then latch the address, and wdata/we for data, into the mem_* registers. Set grant_id, load cnt = MEM_LATENCY-1, and go to ACCESS.
- Winner selection: see Configuration.
- ACCESS: mem_addr and mem_wdata are held.
  - mem_we is high only in the first ACCESS cycle of a store, so there is exactly one write per store.
  - cnt decrements each cycle.
  - At cnt==0, a load or fetch captures mem_rdata into the owner's rdata register. Then go to RESP.
- RESP: pulse the owner's ack for one cycle, then go to IDLE. No grant is made in RESP, so a request still held during the ack cycle is not re-granted.
- Requester inputs that change after the grant are ignored until the next IDLE.
- Deasserting req mid-transaction violates the protocol. The transaction still completes and ack is still pulsed.
- Store completion: d_rdata is unchanged on a store ack.
- cnt is 4 bits wide.

## Timing
- Request sampled high in IDLE at cycle k:
  - ACCESS occupies cycles k+1 .. k+MEM_LATENCY.
  - mem_rdata is sampled at the end of cycle k+MEM_LATENCY.
  - ack is high in cycle k+MEM_LATENCY+1.
  - IDLE resumes in cycle k+MEM_LATENCY+2.
- Throughput: one transaction per MEM_LATENCY+2 cycles. The earliest regrant is the cycle after RESP.
- Reset values, from the cycle after reset is sampled high:
  - state = IDLE, busy = 0, if_ack = 0, d_ack = 0, mem_we = 0.
  - mem_addr = 0, mem_wdata = 0, if_rdata = 0, d_rdata = 0.
  - grant_id = 0; the round-robin pointer favours data.
- Reset mid-transaction aborts it: no ack is issued, and mem_we drops in the next cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requests are sampled in the same IDLE cycle, the requester that did not win the last grant wins.
  - A pointer holds the last winner. It updates only on a grant and resets to "fetch last", so data wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: data always beats fetch.
  - The pointer is not implemented.
- In both modes, a lone requester is always granted immediately.

## Test plan
- Fetch, MEM_LATENCY=2: if_req and if_addr=0x10 in cycle 0, memory returns 0xDEAD -> mem_addr=0x10 in cycles 1–2, if_ack=1 and if_rdata=0xDEAD in cycle 3, busy=0 in cycle 4.
- Store, MEM_LATENCY=2: d_we=1, d_addr=0x40, d_wdata=0x1234 -> mem_we=1 in cycle 1 only, d_ack in cycle 3, d_rdata unchanged.
- Tie with ARB_ROUND_ROBIN_EN: if_req and d_req both held from reset -> grants alternate data, fetch, data; acks in cycles 3, 7, 11.
- Tie without the macro: same stimulus -> data is granted on every grant while d_req stays high, and if_ack never fires.
- Request held through ack: if_req stays high in cycle 3 -> no second grant in cycle 3, new ACCESS starts in cycle 5.
- Reset mid-operation: reset in cycle 2 of a store -> no d_ack, busy=0, mem_we=0 and all outputs 0 from cycle 3; a fresh if_req is granted normally.
